// File: rtl/sprite_sram_loader_if.sv
// sprite_sram_loader_if
//   Bundles the pixel-source handshake and the SRAM write bus of the sprite
//   loader.
//
//   Handshake: a pixel transfers on a rising i_clk edge where both
//   i_pix_valid and o_pix_ready are high. The source holds i_pix_data
//   stable while i_pix_valid is high and ready is low. o_pix_ready is a
//   pure function of loader state and never depends on i_pix_valid.
//
//   Signals:
//     i_pix_valid / i_pix_data : source pixel and its valid flag
//     o_pix_ready              : loader accepts a pixel this cycle
//     o_sram_writing           : SRAM write strobe (WE_N = !o_sram_writing)
//     o_sram_addr / o_sram_data: write address and data, stable while writing
//
//   Modports: master = loader side, slave = source/SRAM side.
interface sprite_sram_loader_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              i_pix_valid;
  logic [DATA_W-1:0] i_pix_data;
  logic              o_pix_ready;
  logic              o_sram_writing;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_sram_data;

  modport master (
    input  i_pix_valid, i_pix_data,
    output o_pix_ready, o_sram_writing, o_sram_addr, o_sram_data
  );

  modport slave (
    output i_pix_valid, i_pix_data,
    input  o_pix_ready, o_sram_writing, o_sram_addr, o_sram_data
  );
endinterface

// File: rtl/sprite_sram_loader.sv
// sprite_sram_loader
//   Streams NUM_OBJECTS sprites of SPRITE_SIZE x SPRITE_SIZE pixels from a
//   pixel source into SRAM, one word per pixel, and emits a tagged opacity
//   bit for every stored pixel.
//
//   Ports:
//     i_clk, i_rst_n   : clock, asynchronous active-low reset
//     i_start          : start pulse, honoured in IDLE or DONE only
//     bus              : pixel handshake + SRAM write bus (master modport)
//     o_object_id      : object of the current pixel
//     o_pixel_counter  : pixel index inside the sprite (V*SPRITE_SIZE + H)
//     o_opacity        : 1 when the pixel differs from TRANSPARENT_KEY
//     o_opacity_valid  : one-cycle qualifier for opacity/object/pixel tags
//     o_busy / o_done  : loading in progress / all objects stored
//     o_checksum       : sum of written words (SPRITE_LOADER_CHECKSUM_EN)
//     o_state          : FSM state for debug (IDLE=0 FETCH=1 WRITE=2 DONE=3)
//
//   Optional feature: define SPRITE_LOADER_CHECKSUM_EN to build the
//   write-data accumulator; otherwise o_checksum is tied to 0.
module sprite_sram_loader #(
  parameter int          ADDR_W          = 20,
  parameter int          DATA_W          = 16,
  parameter int          SPRITE_SIZE     = 32,
  parameter int          NUM_OBJECTS     = 4,
  parameter int          WRITE_CYCLES    = 2,
  parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  sprite_sram_loader_if.master               bus,
  output logic [$clog2(NUM_OBJECTS)-1:0]     o_object_id,
  output logic [2*$clog2(SPRITE_SIZE)-1:0]   o_pixel_counter,
  output logic                               o_opacity,
  output logic                               o_opacity_valid,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [DATA_W-1:0]                  o_checksum,
  output logic [1:0]                         o_state
);

  localparam int OBJ_W = $clog2(NUM_OBJECTS);
  localparam int PIX_W = 2 * $clog2(SPRITE_SIZE);
  localparam int WC_W  = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(SPRITE_SIZE * SPRITE_SIZE - 1);
  localparam logic [OBJ_W-1:0] OBJ_LAST = OBJ_W'(NUM_OBJECTS - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q;
  logic [OBJ_W-1:0]  obj_q;
  logic [PIX_W-1:0]  pix_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              opacity_q;
  logic              writing_q, opv_q, busy_q, done_q;

  logic start_ok, accept, write_last, more_pixels;

  assign start_ok    = i_start && (state_q == IDLE || state_q == DONE);
  assign accept      = (state_q == FETCH) && bus.i_pix_valid;
  assign write_last  = (state_q == WRITE) && (wcnt_q == WC_LAST);
  assign more_pixels = (pix_q != PIX_LAST) || (obj_q != OBJ_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = FETCH;
      FETCH:   if (bus.i_pix_valid) state_d = WRITE;
      WRITE:   if (write_last) state_d = more_pixels ? FETCH : DONE;
      DONE:    if (i_start) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Status flags are registered from the next state so they line up with
  // the state they describe and carry no input-to-output path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      writing_q <= 1'b0;
      opv_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      writing_q <= (state_d == WRITE);
      opv_q     <= accept;
      busy_q    <= (state_d == FETCH) || (state_d == WRITE);
      done_q    <= (state_d == DONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wcnt_q    <= '0;
      obj_q     <= '0;
      pix_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      opacity_q <= 1'b0;
    end else begin
      if (start_ok) begin
        obj_q  <= '0;
        pix_q  <= '0;
        wcnt_q <= '0;
      end
      if (accept) begin
        data_q    <= bus.i_pix_data;
        // SPRITE_SIZE is a power of two, so object*SPRITE_SIZE^2 + pixel
        // is the object id placed above the pixel index bits.
        addr_q    <= (ADDR_W'(obj_q) << PIX_W) | ADDR_W'(pix_q);
        opacity_q <= (bus.i_pix_data != DATA_W'(TRANSPARENT_KEY));
        wcnt_q    <= '0;
      end
      if (state_q == WRITE) begin
        wcnt_q <= write_last ? '0 : wcnt_q + 1'b1;
        if (write_last) begin
          if (pix_q != PIX_LAST) begin
            pix_q <= pix_q + 1'b1;
          end else if (obj_q != OBJ_LAST) begin
            pix_q <= '0;
            obj_q <= obj_q + 1'b1;
          end
        end
      end
    end
  end

`ifdef SPRITE_LOADER_CHECKSUM_EN
  // Accumulated on the accepting edge so the new sum is visible in the
  // first WRITE cycle of each word.
  logic [DATA_W-1:0] csum_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (accept)   csum_q <= csum_q + bus.i_pix_data;
  end
  assign o_checksum = csum_q;
`else
  assign o_checksum = '0;
`endif

  assign bus.o_pix_ready    = (state_q == FETCH);
  assign bus.o_sram_writing = writing_q;
  assign bus.o_sram_addr    = addr_q;
  assign bus.o_sram_data    = data_q;
  assign o_object_id        = obj_q;
  assign o_pixel_counter    = pix_q;
  assign o_opacity          = opacity_q;
  assign o_opacity_valid    = opv_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_state            = state_q;

endmodule

// File: tb/tb_sprite_sram_loader.sv
// tb_sprite_sram_loader
//   Directed bench for sprite_sram_loader with SPRITE_SIZE=2, NUM_OBJECTS=2,
//   WRITE_CYCLES=2. Pixel vectors live in a table of {data, gap, mid-load
//   start, expected address/opacity/object/pixel}; reset, restart and
//   asynchronous reset are hand-written sequences.
module tb_sprite_sram_loader;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  sprite_sram_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [0:0]        object_id;
  logic [1:0]        pixel_counter;
  logic              opacity, opacity_valid, busy, done;
  logic [DATA_W-1:0] checksum;
  logic [1:0]        state;

  sprite_sram_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SPRITE_SIZE(2), .NUM_OBJECTS(2),
    .WRITE_CYCLES(2), .TRANSPARENT_KEY(16'hF81F)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .bus(bus),
    .o_object_id(object_id), .o_pixel_counter(pixel_counter),
    .o_opacity(opacity), .o_opacity_valid(opacity_valid),
    .o_busy(busy), .o_done(done), .o_checksum(checksum), .o_state(state)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] data;
    int          gap;
    bit          start_mid;
    logic [19:0] addr;
    bit          op;
    bit          obj;
    logic [1:0]  pix;
  } vec_t;

  vec_t vecs[16];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_writing"}, bus.o_sram_writing, 0);
    chk({tag, "_addr"}, bus.o_sram_addr, 0);
    chk({tag, "_data"}, bus.o_sram_data, 0);
    chk({tag, "_ready"}, bus.o_pix_ready, 0);
    chk({tag, "_obj"}, object_id, 0);
    chk({tag, "_pix"}, pixel_counter, 0);
    chk({tag, "_op"}, opacity, 0);
    chk({tag, "_opv"}, opacity_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_csum"}, checksum, 0);
    chk({tag, "_state"}, state, 0);
  endtask

  // ---------------- driver ----------------
  task automatic send_pixel(input int idx);
    vec_t v;
    int   w;
    v = vecs[idx];
    for (int g = 0; g < v.gap; g++) begin
      bus.i_pix_valid = 1'b0;
      chk("bp_ready", bus.o_pix_ready, 1);
      chk("bp_nowrite", bus.o_sram_writing, 0);
      tick();
    end
    w = 0;
    while (!bus.o_pix_ready && w < 20) begin
      tick();
      w++;
    end
    chk("ready_wait", bus.o_pix_ready, 1);
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = v.data;
    tick();
    // first WRITE cycle
    if (v.start_mid) start = 1'b1;
    chk("w1_writing", bus.o_sram_writing, 1);
    chk("w1_opv", opacity_valid, 1);
    chk("w1_addr", bus.o_sram_addr, v.addr);
    chk("w1_data", bus.o_sram_data, v.data);
    chk("w1_op", opacity, v.op);
    chk("w1_obj", object_id, v.obj);
    chk("w1_pix", pixel_counter, v.pix);
    chk("w1_ready", bus.o_pix_ready, 0);
    chk("w1_busy", busy, 1);
    tick();
    start = 1'b0;
    // second WRITE cycle
    chk("w2_writing", bus.o_sram_writing, 1);
    chk("w2_opv", opacity_valid, 0);
    chk("w2_addr", bus.o_sram_addr, v.addr);
    chk("w2_data", bus.o_sram_data, v.data);
    chk("w2_ready", bus.o_pix_ready, 0);
    tick();
    chk("post_writing", bus.o_sram_writing, 0);
    chk("post_ready", bus.o_pix_ready, v.addr != 20'd7);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] exp_csum;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    exp_csum = 16'd36;
`else
    exp_csum = 16'd0;
`endif
    //             data      gap mid addr  op obj pix
    vecs[0]  = '{16'h0001, 0, 0, 20'd0, 1, 0, 2'd0};
    vecs[1]  = '{16'h0002, 0, 0, 20'd1, 1, 0, 2'd1};
    vecs[2]  = '{16'h0003, 5, 0, 20'd2, 1, 0, 2'd2};
    vecs[3]  = '{16'h0004, 0, 0, 20'd3, 1, 0, 2'd3};
    vecs[4]  = '{16'h0005, 0, 1, 20'd4, 1, 1, 2'd0};
    vecs[5]  = '{16'h0006, 0, 0, 20'd5, 1, 1, 2'd1};
    vecs[6]  = '{16'h0007, 0, 0, 20'd6, 1, 1, 2'd2};
    vecs[7]  = '{16'h0008, 0, 0, 20'd7, 1, 1, 2'd3};
    vecs[8]  = '{16'hF81F, 0, 0, 20'd0, 0, 0, 2'd0};
    vecs[9]  = '{16'h0001, 0, 0, 20'd1, 1, 0, 2'd1};
    vecs[10] = '{16'hF81F, 0, 0, 20'd2, 0, 0, 2'd2};
    vecs[11] = '{16'hFFFF, 0, 0, 20'd3, 1, 0, 2'd3};
    vecs[12] = '{16'h1234, 0, 0, 20'd4, 1, 1, 2'd0};
    vecs[13] = '{16'hF81F, 0, 0, 20'd5, 0, 1, 2'd1};
    vecs[14] = '{16'h0000, 0, 0, 20'd6, 1, 1, 2'd2};
    vecs[15] = '{16'hF81E, 0, 0, 20'd7, 1, 1, 2'd3};

    bus.i_pix_valid = 1'b0;
    bus.i_pix_data  = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;
    tick();
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = 16'h5555;
    tick();
    chk("idle_ignores_valid", state, 0);

    // run A: data 1..8, backpressure before pixel 3, ignored start mid-load
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("startA_state", state, 1);
    chk("startA_busy", busy, 1);
    for (int i = 0; i < 8; i++) send_pixel(i);
    chk("doneA_done", done, 1);
    chk("doneA_busy", busy, 0);
    chk("doneA_state", state, 3);
    chk("doneA_csum", checksum, exp_csum);
    tick();
    chk("doneA_hold", done, 1);
    chk("doneA_ready", bus.o_pix_ready, 0);

    // run B: restart from DONE, opacity pattern
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("startB_done", done, 0);
    chk("startB_busy", busy, 1);
    chk("startB_obj", object_id, 0);
    chk("startB_pix", pixel_counter, 0);
    for (int i = 8; i < 16; i++) send_pixel(i);
    chk("doneB_done", done, 1);

    // asynchronous reset during the second WRITE cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = 16'hABCD;
    tick();
    chk("arst_w1", bus.o_sram_writing, 1);
    tick();
    chk("arst_w2", bus.o_sram_writing, 1);
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    #3;
    rst_n = 1'b1;
    tick();
    chk("arst_after_state", state, 0);
    chk("arst_after_writing", bus.o_sram_writing, 0);
    bus.i_pix_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sprite_sram_loader.md
# sprite_sram_loader

Upstream loading stage for the render path. After reset or a new round, it streams sprite pixels from a pixel source into the shared SRAM. For every stored pixel it emits an opacity bit, tagged with object id and pixel index, which feeds the per-object opacity mask registers used by the frame decoder. It owns the SRAM write port while loading: top muxes address and DQ on `o_sram_writing`.

## Interface
- `ADDR_W`, 20: SRAM address width.
- `DATA_W`, 16: SRAM data width; one pixel per word.
- `SPRITE_SIZE`, 32: sprite edge in pixels; a power of two, at least 2.
- `NUM_OBJECTS`, 4: sprites loaded per run.
- `WRITE_CYCLES`, 2: cycles the write strobe is held per word; at least 1.
- `TRANSPARENT_KEY`, 16'hF81F: pixel value treated as transparent.
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_start`, in, 1: single-cycle start pulse; honoured only in IDLE or DONE.
- `i_pix_valid`, in, 1: source pixel valid.
- `i_pix_data`, in, DATA_W: source pixel.
- `o_pix_ready`, out, 1: loader accepts a pixel this cycle.
- `o_sram_writing`, out, 1: write strobe; top drives WE_N = !o_sram_writing.
- `o_sram_addr`, out, ADDR_W: write address.
- `o_sram_data`, out, DATA_W: write data.
- `o_object_id`, out, clog2(NUM_OBJECTS): object of the current pixel.
- `o_pixel_counter`, out, 2*clog2(SPRITE_SIZE): index within the sprite; H = cnt % SPRITE_SIZE, V = cnt / SPRITE_SIZE.
- `o_opacity`, out, 1: 1 when the pixel != TRANSPARENT_KEY.
- `o_opacity_valid`, out, 1: one-cycle qualifier for `o_opacity`, `o_object_id` and `o_pixel_counter`.
- `o_busy`, out, 1: high in FETCH or WRITE.
- `o_done`, out, 1: high in DONE.
- `o_checksum`, out, DATA_W: see Configuration.

## Operation
- FSM states are IDLE, FETCH, WRITE and DONE. Reset enters IDLE with counters cleared.
- IDLE or DONE, on `i_start`:
  - clear object and pixel counters and the checksum;
  - go to FETCH.
- FETCH:
  - `o_pix_ready` = 1.
  - When `i_pix_valid` is high, latch the data, compute address and opacity, and go to WRITE.
- WRITE:
  - `o_sram_writing` = 1 for exactly WRITE_CYCLES cycles; address and data stay stable for the whole window.
  - `o_opacity_valid` pulses in the first WRITE cycle only.
  - On the last WRITE cycle, advance:
    - if pixel < SPRITE_SIZE² − 1, increment pixel and go to FETCH;
    - else if object < NUM_OBJECTS − 1, clear pixel, increment object and go to FETCH;
    - else go to DONE.
- Address = object * SPRITE_SIZE² + pixel. Computed in ADDR_W unsigned arithmetic; no overflow is allowed by configuration.
- DONE holds until the next `i_start`, which reloads everything from object 0, pixel 0.
- `i_start` while busy is ignored.
- `i_pix_valid` outside FETCH is ignored; the source must hold data until it sees ready.

## Timing
- Reset values: all outputs 0, and state IDLE.
- Reset is asynchronous, so asserting it mid-write drops `o_sram_writing` immediately; the partially written word is undefined.
- Handshake completes at cycle t. Then:
  - `o_sram_writing`, addr and data are valid from t+1 to t+WRITE_CYCLES;
  - `o_opacity_valid` is high at t+1;
  - `o_pix_ready` is low from t+1 to t+WRITE_CYCLES and high again at t+WRITE_CYCLES+1 unless in DONE.
- Peak throughput is one pixel per WRITE_CYCLES+1 cycles.
- The last pixel's final WRITE cycle is at T; `o_done` rises at T+1 and `o_busy` falls at T+1.
- All outputs are registered; nothing passes combinationally from input to output except `o_pix_ready`, which is state-decoded only.

## Configuration
- `SPRITE_LOADER_CHECKSUM_EN` defined:
  - `o_checksum` accumulates the mod-2^DATA_W sum of every written word;
  - it updates at the first WRITE cycle, clears on `i_start`, and holds through DONE.
- Not defined: `o_checksum` is tied to 0 and no accumulator is built.

## Test plan
- **Basic load.** SPRITE_SIZE=2, NUM_OBJECTS=2, WRITE_CYCLES=2, source always valid with data 1..8 → 8 writes:
  - addr 0..7 carry data 1..8;
  - each strobe is 2 cycles wide;
  - `o_done` is high 3 cycles after the handshake of pixel 8 (T+1).
- **Opacity.** Data sequence {F81F, 0001, F81F, FFFF} for object 0 →
  - `o_opacity` = 0,1,0,1;
  - counters (0,0),(0,1),(0,2),(0,3);
  - one valid pulse each.
- **Backpressure.** `i_pix_valid` low for 5 cycles before pixel 3 →
  - `o_pix_ready` stays high;
  - no strobe;
  - pixel 3 is still written to addr 2.
- **Restart and ignored start.** Pulse `i_start` mid-load → ignored. Pulse `i_start` in DONE → reload begins at addr 0, and `o_done` clears the next cycle.
- **Async reset.** Assert `i_rst_n` low during the 2nd WRITE cycle →
  - `o_sram_writing` = 0 immediately;
  - state IDLE;
  - all outputs 0.
- **Checksum build.** With `SPRITE_LOADER_CHECKSUM_EN` and data 1..8, `o_checksum` = 36. Without the macro, it reads 0.
